// File: rtl/matrix_serial_mul2x2.sv
// Purpose: streaming 2x2 matrix multiply R = A*B. Elements arrive one per accepted
//          transfer (A00,A01,A10,A11,B00,B01,B10,B11), results leave as R00,R01,R10,R11.
//          Arithmetic wraps modulo 2^EW; one multiply-accumulate per compute cycle.
// Ports:   clk/rst (async active-high); in_valid/in_data/in_ready operand stream;
//          out_valid/out_data/out_ready result stream; busy (COMPUTE or OUTPUT);
//          done (one-cycle pulse after the last result transfer).
// Latency: 8 accepts, then 8 compute cycles, then 4 result transfers (20 cycles best case).
module matrix_serial_mul2x2 #(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [EW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [EW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    load_cnt_q, load_cnt_d;
  logic [2:0]    step_q, step_d;
  logic [1:0]    out_idx_q, out_idx_d;
  logic [EW-1:0] acc_q, acc_d;
  logic          done_q, done_d;
  logic [EW-1:0] a_q [4];
  logic [EW-1:0] a_d [4];
  logic [EW-1:0] b_q [4];
  logic [EW-1:0] b_d [4];
  logic [EW-1:0] r_q [4];
  logic [EW-1:0] r_d [4];

  // Step decode: i = s[2], j = s[1], k = s[0]. Matrices stored row-major, index {row,col}.
  logic [1:0]    a_idx, b_idx, r_idx;
  logic [EW-1:0] prod, sum;

  assign a_idx = {step_q[2], step_q[0]};
  assign b_idx = {step_q[0], step_q[1]};
  assign r_idx = {step_q[2], step_q[1]};
  // Both operands and the result are EW bits wide, so the product and sum wrap mod 2^EW.
  assign prod  = a_q[a_idx] * b_q[b_idx];
  assign sum   = (step_q[0] ? acc_q : '0) + prod;

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUTPUT);
  assign busy      = (state_q != LOAD);
  assign done      = done_q;
  assign out_data  = out_valid ? r_q[out_idx_q] : '0;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    step_d     = step_q;
    out_idx_d  = out_idx_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          // Counter values 0..3 address A, 4..7 address B.
          if (load_cnt_q[2]) b_d[load_cnt_q[1:0]] = in_data;
          else               a_d[load_cnt_q[1:0]] = in_data;
          load_cnt_d = load_cnt_q + 3'd1;
          if (load_cnt_q == 3'd7) begin
            state_d = COMPUTE;
            step_d  = 3'd0;
          end
        end
      end
      COMPUTE: begin
        acc_d  = sum;
        if (step_q[0]) r_d[r_idx] = sum;
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d   = OUTPUT;
          out_idx_d = 2'd0;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'd3) begin
            state_d    = LOAD;
            done_d     = 1'b1;
            load_cnt_d = 3'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      step_q     <= '0;
      out_idx_q  <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        r_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      step_q     <= step_d;
      out_idx_q  <= out_idx_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
    end
  end

endmodule

// File: tb/tb_matrix_serial_mul2x2.sv
module tb_matrix_serial_mul2x2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] stim [8];
  logic [7:0] expr [4];

  always #5 clk = ~clk;

  matrix_serial_mul2x2 #(.EW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives at negedges; each element is taken at the following posedge.
  task automatic load8(input bit gaps);
    for (int e = 0; e < 8; e++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = stim[e];
      @(negedge clk);
      if (gaps && e != 7) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Called at the negedge right after the 8th accept edge. The accept cycle is
  // cycle 0; out_valid must first be seen in cycle 9.
  task automatic wait_out(input bit check_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      if (n == 4) begin
        chk("in_ready_compute", in_ready, 0);
        chk("busy_compute", busy, 1);
        chk("out_data_idle", out_data, 0);
      end
      in_valid = 1'b1;  // must be ignored outside LOAD
      in_data  = 8'hAA;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("out_valid_timeout", out_valid, 1);
    if (check_lat) chk("first_out_cycle", n + 1, 9);
  endtask

  task automatic collect4();
    out_ready = 1'b1;
    for (int o = 0; o < 4; o++) begin
      chk("out_valid", out_valid, 1);
      chk("in_ready_output", in_ready, 0);
      chk("out_data", out_data, expr[o]);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("out_valid_after", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1..8 -> 19,22,43,50 with latency check and single done pulse
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    expr = '{8'd19, 8'd22, 8'd43, 8'd50};
    load8(1'b0);
    wait_out(1'b1);
    collect4();
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Wraparound: 20*13 = 260 -> 4
    stim = '{8'd20, 8'd0, 8'd0, 8'd1, 8'd13, 8'd0, 8'd0, 8'd255};
    expr = '{8'd4, 8'd0, 8'd0, 8'd255};
    load8(1'b0);
    wait_out(1'b1);
    collect4();

    // Output stall for 5 cycles holds R00
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    expr = '{8'd19, 8'd22, 8'd43, 8'd50};
    load8(1'b0);
    out_ready = 1'b0;
    wait_out(1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 19);
      @(negedge clk);
    end
    collect4();

    // Gapped input stream
    load8(1'b1);
    wait_out(1'b1);
    collect4();

    // Reset during compute step 3
    load8(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("no_stale_valid", out_valid, 0);
      @(negedge clk);
    end
    load8(1'b0);
    wait_out(1'b1);
    collect4();

    // Back-to-back pairs: 1..8 then all 255s
    load8(1'b0);
    wait_out(1'b1);
    collect4();
    stim = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    expr = '{8'd2, 8'd2, 8'd2, 8'd2};
    load8(1'b0);
    wait_out(1'b1);
    collect4();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/matrix_serial_mul2x2.md
MATRIX_SERIAL_MUL2X2 -- requirements
Module: matrix_serial_mul2x2

Interface
REQ-001 SHALL have parameter EW, default 8, giving the element width in bits for operands, products and results.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, the source presents an element on in_data.
REQ-005 SHALL have port in_data, input, EW, the operand element.
REQ-006 SHALL have port in_ready, output, 1, the block accepts an element this cycle.
REQ-007 SHALL have port out_valid, output, 1, out_data holds a result element.
REQ-008 SHALL have port out_data, output, EW, the result element.
REQ-009 SHALL have port out_ready, input, 1, the sink accepts out_data this cycle.
REQ-010 SHALL have port busy, output, 1, high in COMPUTE or OUTPUT.
REQ-011 SHALL have port done, output, 1, one-cycle pulse after the last result transfer.

Function
REQ-012 SHALL compute R = A*B for 2x2 matrices A and B with elements of EW bits, in a byte-serial streaming form.
REQ-013 SHALL implement a state machine with states LOAD, COMPUTE and OUTPUT.
REQ-014 SHALL count an input transfer only on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD.
REQ-015 SHALL accept elements in order A00, A01, A10, A11, B00, B01, B10, B11 (row-major, A first), using a 3-bit load counter.
REQ-016 SHALL, on the 8th accepted element, transition LOAD->COMPUTE and clear the step counter to 0.
REQ-017 SHALL, in COMPUTE, execute exactly one multiply-accumulate per cycle for step s=0..7, with i=s[2], j=s[1], k=s[0].
REQ-018 SHALL, at each step, set acc = (k==0 ? 0 : acc) + A[i][k]*B[k][j]; the product and the sum SHALL be truncated to EW bits (mod 2^EW), with no saturation and no overflow flag.
REQ-019 SHALL, at each step with k==1, write R[i][j] with the completed sum.
REQ-020 SHALL transition COMPUTE->OUTPUT after step 7; COMPUTE latency SHALL be exactly 8 cycles, and out_valid SHALL rise the cycle after step 7.
REQ-021 SHALL, in OUTPUT, hold out_valid=1 and drive out_data with R00, R01, R10, R11 in that order.
REQ-022 SHALL advance the output index only on out_valid and out_ready both high; out_data SHALL hold stable while out_ready=0.
REQ-023 SHALL, on the 4th output transfer, transition OUTPUT->LOAD, pulse done for one cycle, and clear the load counter.
REQ-024 SHALL ignore in_valid and in_data outside LOAD; operand registers SHALL not change outside LOAD.
REQ-025 SHALL drive out_data=0 when out_valid=0.
REQ-026 SHALL allow in_valid gaps during LOAD; the element count SHALL depend only on accepted transfers.
REQ-027 SHALL make best-case throughput 8 load + 8 compute + 4 output = 20 cycles per matrix pair.

Reset
REQ-028 SHALL, while rst=1, force state=LOAD, in_ready=1, out_valid=0, out_data=0, busy=0 and done=0, and clear all counters, acc, and the A, B and R registers.
REQ-029 SHALL abandon any partial load, compute or output on reset asserted mid-operation, emitting no stale results afterwards.
REQ-030 SHALL accept a new element on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL pass this case: stream 1,2,3,4,5,6,7,8 with out_ready=1 -> outputs 19,22,43,50, then a single done pulse; first out_valid 9 cycles after the 8th accept.
REQ-032 SHALL pass this case: A=[20 0;0 1], B=[13 0;0 255] -> outputs 4,0,0,255 (260 wraps to 4).
REQ-033 SHALL pass this case: out_ready=0 for 5 cycles in OUTPUT -> out_data stays 19 and out_valid stays 1; transfers resume in order when out_ready=1.
REQ-034 SHALL pass this case: in_valid toggles every other cycle during load of 1..8 -> same results 19,22,43,50; in_ready=0 for the whole of COMPUTE and OUTPUT.
REQ-035 SHALL pass this case: rst pulsed at COMPUTE step 3 -> all outputs 0, in_ready=1; a fresh 1..8 load then yields 19,22,43,50.
REQ-036 SHALL pass this case: two back-to-back pairs (1..8, then all 255s) -> second result 2,2,2,2 (255*255=1 mod 256, 1+1=2).
